float_to_fixed_param: RTL and testbench

Parametrised, handshaked converter from IEEE-754-style binary floating point (configurable exponent/mantissa widths) to signed two's-complement fixed point (configurable total/fraction widths). It is the successor to the single-format float-to-fixed converter. It adds:
- run-time rounding mode (truncate / round-nearest-even)
- saturation with overflow, underflow and NaN flags
- a busy indicator

It sits between float-producing arithmetic blocks and the fixed-point datapath, and is driven by a start/acknowledge FSM handshake.

---
 rtl/float_to_fixed_param_pkg.sv | 41 ++++
 rtl/float_to_fixed_param_fx_align_round.sv | 56 +++++
 rtl/float_to_fixed_param.sv | 188 ++++++++++++++++++
 tb/tb_float_to_fixed_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_to_fixed_param_pkg.sv
// Shared types and format helpers for the parametrised float-to-fixed converter.
package float_to_fixed_param_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StShift,
        StRound,
        StPack,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsNorm,
        ClsZero,
        ClsInf,
        ClsNan
    } fclass_e;

    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int sig_width(input int mw);
        return mw + 1;
    endfunction

    function automatic int sh_width(input int ew);
        return ew + 2;
    endfunction

    function automatic logic [63:0] sat_pos(input int fxw);
        return (64'd1 << (fxw - 1)) - 64'd1;
    endfunction

    // Magnitude of the most negative result, -2^(FXW-1).
    function automatic logic [63:0] sat_neg_mag(input int fxw);
        return 64'd1 << (fxw - 1);
    endfunction

endpackage

// File: rtl/float_to_fixed_param_fx_align_round.sv
// Combinational significand alignment with guard/sticky extraction and
// round-nearest-even increment applied to an already-registered aligned value.
module float_to_fixed_param_fx_align_round #(
    parameter int MW  = 23,
    parameter int FXW = 32,
    parameter int SHW = 10
) (
    input  logic                  [MW:0]  sig,
    input  logic signed           [SHW-1:0] sh,
    output logic                  [FXW:0] mag,
    output logic                          g,
    output logic                          s,
    output logic                          pre_ovf,
    input  logic                          mode,
    input  logic                  [FXW:0] mag_in,
    input  logic                          g_in,
    input  logic                          s_in,
    output logic                  [FXW:0] rnd
);

    localparam int SIGW = MW + 1;
    localparam int EXTW = SIGW + MW + 3;

    logic [EXTW-1:0] rwide;
    int              msb_pos;
    int              n;

    always_comb begin
        mag     = '0;
        g       = 1'b0;
        s       = 1'b0;
        pre_ovf = 1'b0;
        rwide   = '0;
        n       = 0;
        msb_pos = MW + int'(sh);
        // Leading one at bit FXW or above cannot be represented for either sign.
        if (msb_pos >= FXW) begin
            pre_ovf = 1'b1;
        end else if (int'(sh) >= 0) begin
            mag = (FXW + 1)'(sig) << int'(sh);
        end else begin
            n = -int'(sh);
            if (n > MW + 2) begin
                s = 1'b1;
            end else begin
                rwide = {sig, {(MW + 3){1'b0}}} >> n;
                mag   = (FXW + 1)'(rwide[EXTW-1:MW+3]);
                g     = rwide[MW+2];
                s     = |rwide[MW+1:0];
            end
        end
    end

    assign rnd = mag_in + (FXW + 1)'(mode & g_in & (s_in | mag_in[0]));

endmodule

// File: rtl/float_to_fixed_param.sv
// Handshaked multi-cycle float to signed fixed-point converter with selectable
// rounding, saturation and overflow/underflow/NaN reporting.
module float_to_fixed_param
    import float_to_fixed_param_pkg::*;
#(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int FXW  = 32,
    parameter int FRAC = 16
) (
    input  logic              CLK,
    input  logic              RST_FF,
    input  logic              Begin_FSM,
    input  logic              ROUND_MODE,
    input  logic [EW+MW:0]    F,
    output logic              ACK,
    output logic              BUSY,
    output logic [FXW-1:0]    RESULT,
    output logic              OVF,
    output logic              UNF,
    output logic              NAN_FLAG
);

    localparam int BIAS = bias_of(EW);
    localparam int SIGW = sig_width(MW);
    localparam int SHW  = sh_width(EW);

    localparam logic [FXW:0]   MAX_POS_MAG = (FXW + 1)'(sat_pos(FXW));
    localparam logic [FXW:0]   MAX_NEG_MAG = (FXW + 1)'(sat_neg_mag(FXW));
    localparam logic [FXW-1:0] SAT_MAX     = FXW'(sat_pos(FXW));
    localparam logic [FXW-1:0] SAT_MIN     = FXW'(sat_neg_mag(FXW));

    state_e                  state_q, state_d;
    logic                    capture;
    logic [EW+MW:0]          f_q;
    logic                    mode_q;

    fclass_e                 cls_d, cls_q;
    logic                    sign_q, mant_nz_q;
    logic [SIGW-1:0]         sig_q;
    logic signed [SHW-1:0]   sh_d, sh_q;
    logic [EW-1:0]           exp_f;
    logic [MW-1:0]           mant_f;

    logic [FXW:0]            mag, mag_q, rnd, rnd_q;
    logic                    g, s, pre_ovf, g_q, s_q, povf_q;

    logic [FXW-1:0]          res_d;
    logic                    ovf_d, unf_d, nan_d;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Begin_FSM) begin
                    state_d = StUnpack;
                    capture = 1'b1;
                end
            end
            StUnpack: state_d = StShift;
            StShift:  state_d = StRound;
            StRound:  state_d = StPack;
            StPack:   state_d = StDone;
            // Back-to-back requests are accepted on the edge that leaves DONE.
            StDone: begin
                if (Begin_FSM) begin
                    state_d = StUnpack;
                    capture = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    assign ACK  = (state_q == StDone);
    assign BUSY = (state_q != StIdle);

    assign exp_f  = f_q[EW+MW-1:MW];
    assign mant_f = f_q[MW-1:0];

    always_comb begin
        if (&exp_f) begin
            cls_d = (mant_f != '0) ? ClsNan : ClsInf;
        end else if (exp_f == '0) begin
            cls_d = ClsZero;
        end else begin
            cls_d = ClsNorm;
        end
        sh_d = SHW'(int'(exp_f) - BIAS + FRAC - MW);
    end

    float_to_fixed_param_fx_align_round #(
        .MW  (MW),
        .FXW (FXW),
        .SHW (SHW)
    ) u_align_round (
        .sig     (sig_q),
        .sh      (sh_q),
        .mag     (mag),
        .g       (g),
        .s       (s),
        .pre_ovf (pre_ovf),
        .mode    (mode_q),
        .mag_in  (mag_q),
        .g_in    (g_q),
        .s_in    (s_q),
        .rnd     (rnd)
    );

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        nan_d = 1'b0;
        unique case (cls_q)
            ClsNan:  nan_d = 1'b1;
            ClsInf: begin
                ovf_d = 1'b1;
                res_d = sign_q ? SAT_MIN : SAT_MAX;
            end
            ClsZero: unf_d = mant_nz_q;
            default: begin
                if (povf_q || (!sign_q && (rnd_q > MAX_POS_MAG)) ||
                    (sign_q && (rnd_q > MAX_NEG_MAG))) begin
                    ovf_d = 1'b1;
                    res_d = sign_q ? SAT_MIN : SAT_MAX;
                end else begin
                    res_d = sign_q ? FXW'(~rnd_q + 1'b1) : rnd_q[FXW-1:0];
                    unf_d = (rnd_q == '0);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            state_q   <= StIdle;
            f_q       <= '0;
            mode_q    <= 1'b0;
            cls_q     <= ClsZero;
            sign_q    <= 1'b0;
            mant_nz_q <= 1'b0;
            sig_q     <= '0;
            sh_q      <= '0;
            mag_q     <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
            povf_q    <= 1'b0;
            rnd_q     <= '0;
            RESULT    <= '0;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
            NAN_FLAG  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                f_q    <= F;
                mode_q <= ROUND_MODE;
            end
            if (state_q == StUnpack) begin
                cls_q     <= cls_d;
                sign_q    <= f_q[EW+MW];
                mant_nz_q <= (mant_f != '0);
                sig_q     <= {1'b1, mant_f};
                sh_q      <= sh_d;
            end
            if (state_q == StShift) begin
                mag_q  <= mag;
                g_q    <= g;
                s_q    <= s;
                povf_q <= pre_ovf;
            end
            if (state_q == StRound) begin
                rnd_q <= rnd;
            end
            if (state_q == StPack) begin
                RESULT   <= res_d;
                OVF      <= ovf_d;
                UNF      <= unf_d;
                NAN_FLAG <= nan_d;
            end
        end
    end

endmodule

// File: tb/tb_float_to_fixed_param.sv
// Self-checking bench: directed vector table, handshake/reset sequences and
// random floats compared against a real-arithmetic reference model.
module tb_float_to_fixed_param;

    localparam int EW   = 8;
    localparam int MW   = 23;
    localparam int FXW  = 32;
    localparam int FRAC = 16;

    logic              CLK = 1'b0;
    logic              RST_FF;
    logic              Begin_FSM;
    logic              ROUND_MODE;
    logic [EW+MW:0]    F;
    logic              ACK;
    logic              BUSY;
    logic [FXW-1:0]    RESULT;
    logic              OVF;
    logic              UNF;
    logic              NAN_FLAG;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] f;
        logic        mode;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        nan;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    float_to_fixed_param #(
        .EW   (EW),
        .MW   (MW),
        .FXW  (FXW),
        .FRAC (FRAC)
    ) dut (
        .CLK        (CLK),
        .RST_FF     (RST_FF),
        .Begin_FSM  (Begin_FSM),
        .ROUND_MODE (ROUND_MODE),
        .F          (F),
        .ACK        (ACK),
        .BUSY       (BUSY),
        .RESULT     (RESULT),
        .OVF        (OVF),
        .UNF        (UNF),
        .NAN_FLAG   (NAN_FLAG)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] f, input logic mode, input logic [31:0] res,
                                input logic ovf, input logic unf, input logic nan);
        vec_t v;
        v.f = f; v.mode = mode; v.res = res; v.ovf = ovf; v.unf = unf; v.nan = nan;
        return v;
    endfunction

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // Exact value of the float times 2^FRAC, then truncated or rounded half-to-even.
    function automatic void model(input logic [31:0] f, input logic mode, output logic [31:0] r,
                                  output logic o, output logic u, output logic n);
        logic   sg;
        int     e;
        longint m, mi;
        real    v, fl, fr, lim;
        sg = f[31];
        e  = int'(f[30:23]);
        m  = longint'(f[22:0]);
        r = '0; o = 1'b0; u = 1'b0; n = 1'b0;
        if (e == 255) begin
            if (m != 0) n = 1'b1;
            else begin
                o = 1'b1;
                r = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (e == 0) begin
            u = (m != 0);
        end else begin
            v  = real'(m + (64'sd1 <<< MW)) * pow2(e - 127 + FRAC - MW);
            fl = $floor(v);
            fr = v - fl;
            if (mode && ((fr > 0.5) || ((fr == 0.5) && ($floor(fl / 2.0) * 2.0 != fl))))
                fl = fl + 1.0;
            lim = sg ? pow2(FXW - 1) : pow2(FXW - 1) - 1.0;
            if (fl > lim) begin
                o = 1'b1;
                r = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                mi = longint'(fl);
                r  = sg ? 32'(-mi) : 32'(mi);
                u  = (mi == 0);
            end
        end
    endfunction

    // Entered #1 after an edge with the FSM idle; leaves it idle again.
    task automatic run_conv(input string name, input logic [31:0] f, input logic mode,
                            input logic [31:0] er, input logic eo, input logic eu,
                            input logic en);
        int lat;
        Begin_FSM  = 1'b1;
        F          = f;
        ROUND_MODE = mode;
        @(posedge CLK); #1;
        Begin_FSM = 1'b0;
        chk({name, "_busy"}, 64'(BUSY), 64'd1);
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!ACK && lat < 12);
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_result"}, 64'(RESULT), 64'(er));
        chk({name, "_flags"}, 64'({OVF, UNF, NAN_FLAG}), 64'({eo, eu, en}));
        @(posedge CLK); #1;
        chk({name, "_idle"}, 64'({ACK, BUSY}), 64'd0);
    endtask

    initial begin
        int         acks, first_ack, w;
        int         ack_edges[$];
        logic [31:0] er;
        logic        eo, eu, en;

        RST_FF = 1'b1; Begin_FSM = 1'b0; ROUND_MODE = 1'b0; F = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", 64'({ACK, BUSY, RESULT, OVF, UNF, NAN_FLAG}), 64'd0);
        RST_FF = 1'b0;
        @(posedge CLK); #1;

        vecs.push_back(mk(32'hC174_0000, 1'b0, 32'hFFF0_C000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h4174_0000, 1'b0, 32'h000F_4000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3F80_0000, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3F93_3333, 1'b0, 32'h0001_2666, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3F93_3333, 1'b1, 32'h0001_2666, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3CCC_CCCD, 1'b0, 32'h0000_0666, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3CCC_CCCD, 1'b1, 32'h0000_0666, 1'b0, 1'b0, 1'b0));
        // 1.5 LSB: truncates to 1, ties to even 2.
        vecs.push_back(mk(32'h37C0_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h37C0_0000, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hB7C0_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hB7C0_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        // 0.75 LSB and 0.5 LSB.
        vecs.push_back(mk(32'h3740_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'h3740_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'h3700_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'h3700_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'h4780_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'h46FF_FFFF, 1'b0, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hC700_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hC700_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'hBF00_0000, 1'b1, 32'hFFFF_8000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFF80_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'h7F80_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(32'h7FC0_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i])
            run_conv($sformatf("vec%0d", i), vecs[i].f, vecs[i].mode, vecs[i].res,
                     vecs[i].ovf, vecs[i].unf, vecs[i].nan);

        // Second request during conversion is dropped.
        Begin_FSM = 1'b1; F = 32'h3F80_0000; ROUND_MODE = 1'b0;
        @(posedge CLK); #1;
        acks = 0; first_ack = -1;
        for (int e = 1; e <= 10; e++) begin
            Begin_FSM = (e == 2);
            if (e == 2) F = 32'h4174_0000;
            @(posedge CLK); #1;
            if (ACK) begin
                acks++;
                if (first_ack < 0) first_ack = e;
            end
        end
        chk("ignore_ack_count", 64'(acks), 64'd1);
        chk("ignore_ack_edge", 64'(first_ack), 64'd4);
        chk("ignore_result", 64'(RESULT), 64'h0001_0000);

        // Held request: one conversion every five cycles.
        Begin_FSM = 1'b1; F = 32'h4174_0000;
        @(posedge CLK); #1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge CLK); #1;
            if (ACK) ack_edges.push_back(e);
        end
        Begin_FSM = 1'b0;
        chk("held_ack_count", 64'(ack_edges.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("held_ack%0d_edge", i),
                64'((i < ack_edges.size()) ? ack_edges[i] : -1), 64'(4 + 5 * i));
        chk("held_result", 64'(RESULT), 64'h000F_4000);
        w = 0;
        while (BUSY && w < 20) begin
            @(posedge CLK); #1;
            w++;
        end
        chk("held_drain", 64'(BUSY), 64'd0);

        // Reset mid-conversion aborts without ACK.
        run_conv("pre_reset", 32'hC700_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        Begin_FSM = 1'b1; F = 32'hC174_0000;
        @(posedge CLK); #1;
        Begin_FSM = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RST_FF = 1'b1;
        #1 chk("async_reset", 64'({ACK, BUSY, RESULT, OVF, UNF, NAN_FLAG}), 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST_FF = 1'b0;
        acks = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge CLK); #1;
            if (ACK || BUSY) acks++;
        end
        chk("post_reset_quiet", 64'(acks), 64'd0);
        run_conv("post_reset", 32'hC174_0000, 1'b0, 32'hFFF0_C000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] f;
            logic        md;
            int          sel;
            sel      = $urandom_range(0, 15);
            f[31]    = 1'($urandom_range(0, 1));
            f[22:0]  = 23'($urandom);
            f[30:23] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'hFF : 8'($urandom_range(100, 146));
            if (sel == 2) f[22:0] = '0;
            md = 1'($urandom_range(0, 1));
            model(f, md, er, eo, eu, en);
            run_conv($sformatf("rnd%0d_%08h_m%0d", i, f, md), f, md, er, eo, eu, en);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
